// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: ALU opcodes and sequencer FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        SHL  = 3'd5,
        SHR  = 3'd6,
        PASS = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between a command source and the sequencer.
interface alu_cmd_sequencer_if #(
    parameter int SIZE  = 4,
    parameter int NREGS = 4
);
    localparam int RAW = $clog2(NREGS);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_opcode;
    logic [RAW-1:0]  cmd_rd;
    logic [RAW-1:0]  cmd_rs1;
    logic [RAW-1:0]  cmd_rs2;
    logic            cmd_use_imm;
    logic [SIZE-1:0] cmd_imm;

    logic            resp_valid;
    logic            resp_ready;
    logic [SIZE-1:0] resp_result;
    logic            resp_carry;
    logic [RAW-1:0]  resp_rd;

    modport master (
        output cmd_valid, cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
        input  cmd_ready,
        input  resp_valid, resp_result, resp_carry, resp_rd,
        output resp_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
        output cmd_ready,
        output resp_valid, resp_result, resp_carry, resp_rd,
        input  resp_ready
    );

endinterface

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module alu_regfile #(
    parameter  int SIZE  = 4,
    parameter  int NREGS = 4,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RAW-1:0]  raddr_a,
    output logic [SIZE-1:0] rdata_a,
    input  logic [RAW-1:0]  raddr_b,
    output logic [SIZE-1:0] rdata_b,
    input  logic            we,
    input  logic [RAW-1:0]  waddr,
    input  logic [SIZE-1:0] wdata
);

    logic [SIZE-1:0] regs [NREGS];

    // NOTE: this array is reset because a reset must clear architectural state; it stays
    // flop-based and is not meant to map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Serial command-issue stage feeding an external simple_alu: operand fetch, execute, writeback, response.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter  int SIZE  = 4,
    parameter  int NREGS = 4,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus,
    output logic [SIZE-1:0]     alu_a,
    output logic [SIZE-1:0]     alu_b,
    output logic [2:0]          alu_opcode,
    input  logic [SIZE-1:0]     alu_result,
    input  logic                alu_carry
);

    seq_state_e      state, state_nx;
    logic            accept;
    logic            exec_done;
    logic [RAW-1:0]  rd_q;
    logic [SIZE-1:0] rf_rdata_a;
    logic [SIZE-1:0] rf_rdata_b;

    alu_regfile #(
        .SIZE  (SIZE),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (bus.cmd_rs1),
        .rdata_a (rf_rdata_a),
        .raddr_b (bus.cmd_rs2),
        .rdata_b (rf_rdata_b),
        .we      (exec_done),
        .waddr   (rd_q),
        .wdata   (alu_result)
    );

    // NOTE: all state is updated with non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        exec_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                exec_done = 1'b1;
                state_nx  = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ALU drive registers are loaded at accept and hold their value until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a           <= '0;
            alu_b           <= '0;
            alu_opcode      <= '0;
            rd_q            <= '0;
            bus.resp_result <= '0;
            bus.resp_carry  <= 1'b0;
            bus.resp_rd     <= '0;
        end else begin
            if (accept) begin
                alu_a      <= rf_rdata_a;
                alu_b      <= bus.cmd_use_imm ? bus.cmd_imm : rf_rdata_b;
                alu_opcode <= bus.cmd_opcode;
                rd_q       <= bus.cmd_rd;
            end
            if (exec_done) begin
                bus.resp_result <= alu_result;
                bus.resp_carry  <= alu_carry;
                bus.resp_rd     <= rd_q;
            end
        end
    end

    assign bus.cmd_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural simple_alu wired to its alu_* ports.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int SIZE  = 4;
    localparam int NREGS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.SIZE(SIZE), .NREGS(NREGS)) bus ();

    logic [SIZE-1:0] alu_a, alu_b, alu_result;
    logic [2:0]      alu_opcode;
    logic            alu_carry;

    alu_cmd_sequencer #(.SIZE(SIZE), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry)
    );

    // Reference simple_alu: carry is ADD carry-out or SUB borrow; shift amount uses all of b.
    logic [SIZE:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_op_e'(alu_opcode))
            ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            AND:  alu_wide = {1'b0, alu_a & alu_b};
            OR:   alu_wide = {1'b0, alu_a | alu_b};
            XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
            SHL:  alu_wide = {1'b0, alu_a << alu_b};
            SHR:  alu_wide = {1'b0, alu_a >> alu_b};
            PASS: alu_wide = {1'b0, alu_a};
            default: alu_wide = '0;
        endcase
    end
    assign alu_result = alu_wide[SIZE-1:0];
    assign alu_carry  = alu_wide[SIZE];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;
    int t_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the EXEC cycle.
    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic ui, input logic [3:0] imm);
        bus.cmd_opcode  = op;
        bus.cmd_rd      = rd;
        bus.cmd_rs1     = rs1;
        bus.cmd_rs2     = rs2;
        bus.cmd_use_imm = ui;
        bus.cmd_imm     = imm;
        bus.cmd_valid   = 1'b1;
        check("accept_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        t_acc = cyc;
    endtask

    // Called at the EXEC negedge with resp_ready=1; returns at the following IDLE negedge.
    task automatic expect_resp(input string tag, input logic [3:0] res, input logic c,
                               input logic [1:0] rd);
        check({tag, "_exec_rv"}, {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_rv"},     {31'd0, bus.resp_valid}, 32'd1);
        check({tag, "_result"}, {28'd0, bus.resp_result}, {28'd0, res});
        check({tag, "_carry"},  {31'd0, bus.resp_carry}, {31'd0, c});
        check({tag, "_rd"},     {30'd0, bus.resp_rd}, {30'd0, rd});
        @(negedge clk);
        check({tag, "_done_rv"}, {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = '0;
        bus.cmd_rd      = '0;
        bus.cmd_rs1     = '0;
        bus.cmd_rs2     = '0;
        bus.cmd_use_imm = 1'b0;
        bus.cmd_imm     = '0;
        bus.resp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_cmd_ready",   {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_resp_valid",  {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_result", {28'd0, bus.resp_result}, 32'd0);
        check("rst_resp_carry",  {31'd0, bus.resp_carry}, 32'd0);
        check("rst_resp_rd",     {30'd0, bus.resp_rd}, 32'd0);
        check("rst_alu_a",       {28'd0, alu_a}, 32'd0);
        check("rst_alu_b",       {28'd0, alu_b}, 32'd0);
        check("rst_alu_opcode",  {29'd0, alu_opcode}, 32'd0);

        // 1: r1 = 0 + 5
        send(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5);
        check("t1_alu_a",      {28'd0, alu_a}, 32'd0);
        check("t1_alu_b",      {28'd0, alu_b}, 32'd5);
        check("t1_alu_opcode", {29'd0, alu_opcode}, 32'd0);
        check("t1_cmd_ready",  {31'd0, bus.cmd_ready}, 32'd0);
        expect_resp("t1", 4'd5, 1'b0, 2'd1);

        // 2: r2 = 5 + 12 wraps to 1 with carry; read back r2
        send(ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'd12);
        expect_resp("t2", 4'd1, 1'b1, 2'd2);
        send(PASS, 2'd0, 2'd2, 2'd0, 1'b1, 4'd0);
        expect_resp("t2_pass", 4'd1, 1'b0, 2'd0);

        // 3: write to r0 is reported but discarded
        send(ADD, 2'd0, 2'd1, 2'd0, 1'b1, 4'd3);
        expect_resp("t3", 4'd8, 1'b0, 2'd0);
        send(PASS, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0);
        expect_resp("t3_pass", 4'd0, 1'b0, 2'd0);

        // 4: backpressure, r3 = 5 + 1; commands offered during RESP must be ignored
        bus.resp_ready = 1'b0;
        send(ADD, 2'd3, 2'd1, 2'd0, 1'b1, 4'd1);
        check("t4_exec_rv", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        bus.cmd_opcode  = ADD;
        bus.cmd_rd      = 2'd3;
        bus.cmd_rs1     = 2'd1;
        bus.cmd_use_imm = 1'b1;
        bus.cmd_imm     = 4'd9;
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_rv",     {31'd0, bus.resp_valid}, 32'd1);
            check("t4_hold_result", {28'd0, bus.resp_result}, 32'd6);
            check("t4_hold_rd",     {30'd0, bus.resp_rd}, 32'd3);
            check("t4_hold_ready",  {31'd0, bus.cmd_ready}, 32'd0);
            check("t4_hold_alu_a",  {28'd0, alu_a}, 32'd5);
            bus.cmd_valid = (i % 2 == 0);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("t4_still_rv", {31'd0, bus.resp_valid}, 32'd1);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("t4_taken_rv",    {31'd0, bus.resp_valid}, 32'd0);
        check("t4_taken_ready", {31'd0, bus.cmd_ready}, 32'd1);
        send(PASS, 2'd0, 2'd3, 2'd0, 1'b1, 4'd0);
        expect_resp("t4_pass", 4'd6, 1'b0, 2'd0);

        // 5: reset during EXEC drops the writeback and clears the register file
        send(ADD, 2'd3, 2'd1, 2'd0, 1'b1, 4'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rv",     {31'd0, bus.resp_valid}, 32'd0);
        check("t5_ready",  {31'd0, bus.cmd_ready}, 32'd1);
        check("t5_result", {28'd0, bus.resp_result}, 32'd0);
        @(negedge clk);
        check("t5_idle_rv", {31'd0, bus.resp_valid}, 32'd0);
        send(PASS, 2'd0, 2'd3, 2'd0, 1'b1, 4'd0);
        expect_resp("t5_pass_r3", 4'd0, 1'b0, 2'd0);
        send(PASS, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0);
        expect_resp("t5_pass_r1", 4'd0, 1'b0, 2'd0);

        // 6: back-to-back issue; r1 = 1, r1 = 1 << 2, r2 = 4 - 5
        send(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'd1);
        t_prev = t_acc;
        expect_resp("t6_add", 4'd1, 1'b0, 2'd1);
        send(SHL, 2'd1, 2'd1, 2'd0, 1'b1, 4'd2);
        check("t6_gap_shl", t_acc - t_prev, 32'd3);
        t_prev = t_acc;
        expect_resp("t6_shl", 4'd4, 1'b0, 2'd1);
        send(SUB, 2'd2, 2'd1, 2'd0, 1'b1, 4'd5);
        check("t6_gap_sub", t_acc - t_prev, 32'd3);
        expect_resp("t6_sub", 4'd15, 1'b1, 2'd2);

        // Register-sourced B, and shifts using the full-width amount
        send(AND, 2'd0, 2'd2, 2'd1, 1'b0, 4'd0);
        check("t7_alu_b", {28'd0, alu_b}, 32'd4);
        expect_resp("t7_and", 4'd4, 1'b0, 2'd0);
        send(SHL, 2'd0, 2'd2, 2'd0, 1'b1, 4'd4);
        expect_resp("t7_shl_wide", 4'd0, 1'b0, 2'd0);
        send(SHR, 2'd0, 2'd2, 2'd0, 1'b1, 4'd3);
        expect_resp("t7_shr", 4'd1, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
